// File: rtl/log_arbiter.sv
// log_arbiter: collects log records from NUM_REQ requesters with a round-robin
// grant and frames each session in an output stream as OPEN, RECORD..., CLOSE.
// Entries are buffered in a FIFO_DEPTH-entry FIFO with no fall-through.
// Optional feature: define LOG_TIMESTAMP_EN to stamp every entry with a
// free-running 32-bit cycle count taken at push time (out_time_o is 0 otherwise).
module log_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int REC_W      = 64,
  parameter int FIFO_DEPTH = 8,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*REC_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     out_ready_i,
  output logic                     out_valid_o,
  output logic [1:0]               out_kind_o,
  output logic [SRC_W-1:0]         out_src_o,
  output logic [REC_W-1:0]         out_data_o,
  output logic [31:0]              out_time_o,
  output logic                     active_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] KIND_RECORD = 2'b00;
  localparam logic [1:0] KIND_OPEN   = 2'b01;
  localparam logic [1:0] KIND_CLOSE  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN,
    S_RUN,
    S_DRAIN,
    S_CLOSE
  } state_t;

  state_t           state;
  logic             stop_lat;
  logic             active_q;
  logic [SRC_W-1:0] rr_ptr;

  // FIFO storage (payload arrays are not reset; validity comes from count)
  logic [1:0]       kind_mem [FIFO_DEPTH];
  logic [SRC_W-1:0] src_mem  [FIFO_DEPTH];
  logic [REC_W-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             fifo_empty;

  logic             grant_any;
  logic [SRC_W-1:0] grant_idx;
  logic             xfer;
  logic             push;
  logic             pop;
  logic [1:0]       push_kind;
  logic [SRC_W-1:0] push_src;
  logic [REC_W-1:0] push_data;

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Round-robin search: first valid requester strictly after the last granted one
  always_comb begin
    logic [SRC_W-1:0] cand;
    cand      = rr_ptr;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == SRC_W'(NUM_REQ-1)) ? '0 : cand + SRC_W'(1);
      if (!grant_any && req_valid_i[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Ready is one-hot to the winner only while running and the buffer has room
  always_comb begin
    req_ready_o = '0;
    if (state == S_RUN && !fifo_full && grant_any) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  assign xfer = |(req_ready_o & req_valid_i);
  assign pop  = out_valid_o & out_ready_i;

  // Select what, if anything, enters the FIFO this cycle
  always_comb begin
    push      = 1'b0;
    push_kind = KIND_RECORD;
    push_src  = '0;
    push_data = '0;
    case (state)
      S_OPEN: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_kind = KIND_OPEN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          push      = 1'b1;
          push_src  = grant_idx;
          push_data = req_data_i[int'(grant_idx)*REC_W +: REC_W];
        end
      end
      S_DRAIN: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_kind = KIND_CLOSE;
        end
      end
      default: ;
    endcase
  end

  // Session FSM; a stop seen in OPEN is held until RUN can act on it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= S_IDLE;
      stop_lat <= 1'b0;
      active_q <= 1'b0;
      rr_ptr   <= SRC_W'(NUM_REQ-1);
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state    <= S_OPEN;
            active_q <= 1'b1;
          end
        end
        S_OPEN: begin
          if (stop_i) stop_lat <= 1'b1;
          if (!fifo_full) state <= S_RUN;
        end
        S_RUN: begin
          if (xfer) rr_ptr <= grant_idx;
          if (stop_i || stop_lat) begin
            state    <= S_DRAIN;
            stop_lat <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!fifo_full) state <= S_CLOSE;
        end
        S_CLOSE: begin
          // leave once the CLOSE beat (the last entry) has been taken
          if (fifo_empty || (count == (PTR_W+1)'(1) && pop)) begin
            state    <= S_IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign active_o = active_q;

  // FIFO pointers and occupancy; reset discards anything buffered
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // FIFO payload write
  always_ff @(posedge clk_i) begin
    if (push) begin
      kind_mem[wr_ptr] <= push_kind;
      src_mem[wr_ptr]  <= push_src;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Outputs read the FIFO head and read as zero whenever nothing is buffered
  assign out_valid_o = !fifo_empty;
  assign out_kind_o  = fifo_empty ? '0 : kind_mem[rd_ptr];
  assign out_src_o   = fifo_empty ? '0 : src_mem[rd_ptr];
  assign out_data_o  = fifo_empty ? '0 : data_mem[rd_ptr];

`ifdef LOG_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] time_mem [FIFO_DEPTH];

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
    end
  end

  // Stamp each entry with the count of the cycle it was pushed in
  always_ff @(posedge clk_i) begin
    if (push) time_mem[wr_ptr] <= ts_cnt;
  end

  assign out_time_o = fifo_empty ? '0 : time_mem[rd_ptr];
`else
  assign out_time_o = '0;
`endif

endmodule

// File: doc/log_arbiter.md
LOG_ARBITER -- requirements
Module: log_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of log requesters (2..8).
REQ-002 SHALL have parameter REC_W, default 64, log record payload width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, output buffer depth in entries (power of two, >= 2).
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1, single-cycle pulse that opens a log session.
REQ-007 SHALL have port stop_i, input, 1, single-cycle pulse that closes the session.
REQ-008 SHALL have port req_valid_i, input, NUM_REQ, per-requester record valid.
REQ-009 SHALL have port req_data_i, input, NUM_REQ*REC_W, packed records; requester k occupies bits [k*REC_W +: REC_W].
REQ-010 SHALL have port req_ready_o, output, NUM_REQ, per-requester accept; transfer occurs when valid and ready are both high.
REQ-011 SHALL have port out_valid_o, input-side ready out_ready_i (input, 1), and out_valid_o (output, 1): output stream handshake.
REQ-012 SHALL have port out_kind_o, output, 2: 00 RECORD, 01 OPEN, 10 CLOSE, 11 reserved, never emitted.
REQ-013 SHALL have port out_src_o, output, clog2(NUM_REQ), requester index; 0 for OPEN/CLOSE.
REQ-014 SHALL have port out_data_o, output, REC_W, record payload; 0 for OPEN/CLOSE.
REQ-015 SHALL have port out_time_o, output, 32, acceptance timestamp; see Configuration.
REQ-016 SHALL have port active_o, output, 1, high while a session is open (states OPEN, RUN, DRAIN, CLOSE).

Function
REQ-017 SHALL implement states IDLE, OPEN, RUN, DRAIN, CLOSE.
REQ-018 IDLE: start_i -> OPEN; stop_i ignored; req_ready_o all 0.
REQ-019 OPEN: push one OPEN entry into the FIFO when it is not full, then enter RUN; stop_i is latched and honoured in RUN.
REQ-020 RUN: round-robin grant among valid requesters, starting one index above the last granted, wrapping NUM_REQ-1 -> 0; at most one grant per cycle.
REQ-021 RUN: req_ready_o is one-hot to the granted requester only when the FIFO is not full, and all 0 when the FIFO is full.
REQ-022 RUN: the last-granted pointer advances only on an actual transfer.
REQ-023 stop_i, or a latched stop, in RUN -> DRAIN; a record transferring in the same cycle is still accepted.
REQ-024 DRAIN: no new grants; push one CLOSE entry when the FIFO is not full, then enter CLOSE.
REQ-025 CLOSE: wait until the FIFO is empty and the final output beat has handshaken, then enter IDLE.
REQ-026 start_i outside IDLE SHALL be ignored.
REQ-027 The FIFO SHALL support a simultaneous push and pop when full or empty without loss; no fall-through, so the minimum latency from accept to out_valid_o is 1 cycle.
REQ-028 The output SHALL hold out_* stable while out_valid_o=1 and out_ready_i=0.
REQ-029 Stream order SHALL be exactly one OPEN, then zero or more RECORDs, then exactly one CLOSE per session.

Reset
REQ-030 On reset_n_i low: state IDLE, FIFO empty, round-robin pointer NUM_REQ-1, timestamp 0, latched stop 0.
REQ-031 On reset_n_i low: out_valid_o=0, req_ready_o=0, active_o=0, and out_kind_o, out_src_o, out_data_o, out_time_o all 0.
REQ-032 Reset asserted mid-session SHALL discard buffered entries; no CLOSE is emitted.

Configuration
REQ-033 With LOG_TIMESTAMP_EN defined: a free-running 32-bit cycle counter (wraps 0xFFFFFFFF -> 0) is stored per FIFO entry at push and presented on out_time_o.
REQ-034 Without LOG_TIMESTAMP_EN: no counter or timestamp storage is built, and out_time_o is tied to 0.

Verification
REQ-035 Reset, start_i at cycle 2, out_ready_i=1 -> OPEN beat at cycle 4, then active_o=1.
REQ-036 All 4 requesters valid continuously in RUN -> grants 0,1,2,3,0 on consecutive cycles.
REQ-037 out_ready_i=0 with requester 2 valid -> exactly FIFO_DEPTH-1 records accepted after OPEN, then req_ready_o=0 with out_* held stable.
REQ-038 stop_i in the same cycle requester 1 transfers data 0xDEAD -> RECORD(src 1, 0xDEAD) followed by CLOSE, then active_o=0.
REQ-039 With LOG_TIMESTAMP_EN: record accepted at cycle 10 after reset -> out_time_o=10; without the macro, out_time_o=0.
REQ-040 reset_n_i pulsed low mid-RUN with 3 entries buffered -> out_valid_o=0 immediately and the state returns to IDLE.
